sonar_frame_capture: RTL and testbench

- Sits directly downstream of i2s_if and consumes its 64-bit AXI-Stream of I2S word pairs (two SD lanes, tuser = WS channel flag).
- On a start pulse, pairs left and right beats into 4-channel frames (2 lanes × L/R, 24-bit signed).
- Emits exactly CAPTURE_LEN frames as one tlast-terminated AXI-Stream packet for the sonar ping-processing chain.
- Records sticky overflow and sync-error flags.

---
 rtl/sonar_pkg.sv | 26 ++
 rtl/sonar_frame_capture_if.sv | 14 +
 rtl/sfc_skid_buf.sv | 58 +++++
 rtl/sonar_frame_capture.sv | 173 +++++++++++++++++
 tb/tb_sonar_frame_capture.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sonar_pkg.sv
// Shared constants and types for the sonar frame capture block: lane-word layout,
// frame channel ordering and the capture FSM state set.
package sonar_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int LANE_W       = 32;
  localparam int LANE_MSB     = 31;
  localparam int LANES        = 2;
  localparam int CH_PER_LANE  = 2;
  localparam int NUM_CH       = LANES * CH_PER_LANE;
  localparam int TS_W         = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HAVE_L,
    ST_SYNC_L,
    ST_DRAIN
  } sfc_state_t;

  // Output channel slot: within each lane the left sample precedes the right one.
  function automatic int ch_slot(input int lane, input logic is_right);
    return lane * CH_PER_LANE + (is_right ? 1 : 0);
  endfunction

endpackage

// File: rtl/sonar_frame_capture_if.sv
// AXI-Stream bundle used for both the I2S input stream and the frame output stream.
interface sonar_frame_capture_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/sfc_skid_buf.sv
// Two-entry AXI-Stream buffer (output register plus skid slot) on a packed payload.
// A push that finds both entries occupied and no pop in the same cycle is discarded.
module sfc_skid_buf #(
  parameter int PAY_W = 97
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PAY_W-1:0] push_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_data
);

  logic             out_valid_reg;
  logic [PAY_W-1:0] out_data_reg;
  logic             skid_valid_reg;
  logic [PAY_W-1:0] skid_data_reg;
  logic             pop;

  assign pop       = out_valid_reg && out_ready;
  assign full      = out_valid_reg && skid_valid_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (pop) begin
      if (skid_valid_reg) begin
        out_data_reg <= skid_data_reg;
        if (push) begin
          skid_data_reg <= push_data;
        end else begin
          skid_valid_reg <= 1'b0;
        end
      end else if (push) begin
        out_data_reg <= push_data;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (push) begin
      // Output register is held stable while stalled; newer frames queue behind it.
      if (!out_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= push_data;
      end else if (!skid_valid_reg) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= push_data;
      end
    end
  end

endmodule

// File: rtl/sonar_frame_capture.sv
// Pairs I2S left/right beats into 4-channel frames and emits CAPTURE_LEN of them as one packet.
// Optional SFC_TIMESTAMP_EN adds a right-beat count on m_axis.tuser.
module sonar_frame_capture
  import sonar_pkg::*;
#(
  parameter int CAPTURE_LEN = 1024,
  parameter int SAMPLE_W    = SAMPLE_W_DEF
) (
  input  logic axis_aclk,
  input  logic axis_arstn,
  input  logic start,
  output logic busy,
  output logic overflow,
  output logic sync_err,
  sonar_frame_capture_if.slave  s_axis,
  sonar_frame_capture_if.master m_axis
);

  localparam int FRAME_W = NUM_CH * SAMPLE_W;
  localparam int CNT_W   = $clog2(CAPTURE_LEN + 1);
`ifdef SFC_TIMESTAMP_EN
  localparam int PAY_W   = TS_W + 1 + FRAME_W;
`else
  localparam int PAY_W   = 1 + FRAME_W;
`endif

  sfc_state_t          state_reg, state_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [SAMPLE_W-1:0] held_l_reg [LANES];
  logic [SAMPLE_W-1:0] held_l_next [LANES];
  logic [SAMPLE_W-1:0] lane_sample [LANES];
  logic                overflow_reg, overflow_next;
  logic                sync_err_reg, sync_err_next;
  logic                tready_reg;
  logic                beat_l, beat_r;
  logic [FRAME_W-1:0]  frame;
  logic                push, push_last;
  logic                buf_full, full_stall, pop_last;
  logic [PAY_W-1:0]    push_payload, out_payload;

  assign s_axis.tready = tready_reg;
  assign beat_l        = s_axis.tvalid && tready_reg && !s_axis.tuser[0];
  assign beat_r        = s_axis.tvalid && tready_reg && s_axis.tuser[0];
  assign busy          = (state_reg != ST_IDLE);
  assign overflow      = overflow_reg;
  assign sync_err      = sync_err_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_sample[gi] = s_axis.tdata[gi*LANE_W + LANE_MSB -: SAMPLE_W];
      assign frame[ch_slot(gi, 1'b0)*SAMPLE_W +: SAMPLE_W] = held_l_reg[gi];
      assign frame[ch_slot(gi, 1'b1)*SAMPLE_W +: SAMPLE_W] = lane_sample[gi];
    end
  endgenerate

  // A push this cycle is lost only when both buffer entries are held and nothing leaves.
  assign full_stall = buf_full && !m_axis.tready;
  assign pop_last   = m_axis.tvalid && m_axis.tready && m_axis.tlast;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    held_l_next   = held_l_reg;
    overflow_next = overflow_reg;
    sync_err_next = sync_err_reg;
    push          = 1'b0;
    push_last     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          overflow_next = 1'b0;
          sync_err_next = 1'b0;
          count_next    = '0;
          state_next    = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (beat_l) begin
          held_l_next = lane_sample;
          state_next  = ST_HAVE_L;
        end
      end
      ST_HAVE_L: begin
        if (beat_r) begin
          push       = 1'b1;
          count_next = count_reg + CNT_W'(1);
          if (full_stall) begin
            overflow_next = 1'b1;
          end
          if (count_next == CNT_W'(CAPTURE_LEN)) begin
            push_last  = 1'b1;
            state_next = full_stall ? ST_IDLE : ST_DRAIN;
          end else begin
            state_next = ST_SYNC_L;
          end
        end else if (beat_l) begin
          held_l_next   = lane_sample;
          sync_err_next = 1'b1;
        end
      end
      ST_SYNC_L: begin
        if (beat_l) begin
          held_l_next = lane_sample;
          state_next  = ST_HAVE_L;
        end else if (beat_r) begin
          sync_err_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (pop_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_arstn) begin
    if (!axis_arstn) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      sync_err_reg <= 1'b0;
      tready_reg   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        held_l_reg[i] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      sync_err_reg <= sync_err_next;
      tready_reg   <= 1'b1;
      held_l_reg   <= held_l_next;
    end
  end

`ifdef SFC_TIMESTAMP_EN
  logic [TS_W-1:0] ts_reg;

  always_ff @(posedge axis_aclk or negedge axis_arstn) begin
    if (!axis_arstn) begin
      ts_reg <= '0;
    end else if (beat_r) begin
      ts_reg <= ts_reg + TS_W'(1);
    end
  end

  // The frame carries the count including its own completing right beat.
  assign push_payload = {ts_reg + TS_W'(1), push_last, frame};
  assign m_axis.tuser = out_payload[PAY_W-1 -: TS_W];
`else
  assign push_payload = {push_last, frame};
  assign m_axis.tuser = '0;
`endif

  assign m_axis.tdata = out_payload[FRAME_W-1:0];
  assign m_axis.tlast = out_payload[FRAME_W];

  sfc_skid_buf #(
    .PAY_W (PAY_W)
  ) u_buf (
    .clk       (axis_aclk),
    .rst_n     (axis_arstn),
    .push      (push),
    .push_data (push_payload),
    .full      (buf_full),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (out_payload)
  );

endmodule

// File: tb/tb_sonar_frame_capture.sv
// Self-checking bench for sonar_frame_capture (CAPTURE_LEN=4): queue-based frame model with
// a per-cycle compare process, plus directed vectors with literal expectations.
`timescale 1ns/1ps
module tb_sonar_frame_capture;

  localparam int LEN = 4;
`ifdef SFC_TIMESTAMP_EN
  localparam int UW = 32;
`else
  localparam int UW = 1;
`endif

  typedef struct packed {
    logic [95:0] d;
    logic        l;
    logic [31:0] u;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, overflow, sync_err;
  logic        s_valid, s_user, m_ready;
  logic [63:0] s_data;

  int checks = 0;
  int errors = 0;

  sonar_frame_capture_if #(.DATA_W(64), .USER_W(1))  s_if ();
  sonar_frame_capture_if #(.DATA_W(96), .USER_W(UW)) m_if ();

  assign s_if.tdata    = s_data;
  assign s_if.tvalid   = s_valid;
  assign s_if.tuser[0] = s_user;
  assign s_if.tlast    = 1'b0;
  assign m_if.tready   = m_ready;

  sonar_frame_capture #(.CAPTURE_LEN(LEN), .SAMPLE_W(24)) dut (
    .axis_aclk  (clk),
    .axis_arstn (rst_n),
    .start      (start),
    .busy       (busy),
    .overflow   (overflow),
    .sync_err   (sync_err),
    .s_axis     (s_if),
    .m_axis     (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  exp_t        q[$];
  bit          m_busy, m_capt, m_have_l, m_ovf, m_serr, m_tready;
  int          m_frames;
  logic [23:0] m_l0, m_l1;
  logic [31:0] m_ts;

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_capt = 0; m_have_l = 0; m_ovf = 0; m_serr = 0; m_tready = 0;
    m_frames = 0; m_ts = 0;
  endtask

  task automatic model_step();
    exp_t popped, nf;
    bit   pop, full_before, push_new;
    pop         = (q.size() > 0) && m_ready;
    full_before = (q.size() == 2);
    push_new    = 0;
    nf          = '0;
    if (m_tready && s_valid && s_user) m_ts++;
    if (start && !m_busy) begin
      m_ovf = 0; m_serr = 0; m_frames = 0; m_have_l = 0; m_capt = 1; m_busy = 1;
    end else if (m_capt && m_tready && s_valid) begin
      if (!s_user) begin
        if (m_have_l) m_serr = 1;
        m_l0 = s_data[31:8];
        m_l1 = s_data[63:40];
        m_have_l = 1;
      end else if (m_have_l) begin
        m_have_l = 0;
        m_frames++;
        nf.d = {s_data[63:40], m_l1, s_data[31:8], m_l0};
        nf.l = (m_frames == LEN);
        nf.u = m_ts;
        if (nf.l) m_capt = 0;
        if (full_before && !pop) begin
          m_ovf = 1;
          if (nf.l) m_busy = 0;
        end else begin
          push_new = 1;
        end
      end else if (m_frames > 0) begin
        m_serr = 1;
      end
    end
    if (pop) begin
      popped = q.pop_front();
      if (popped.l && !m_capt) m_busy = 0;
    end
    if (push_new) q.push_back(nf);
    m_tready = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_busy", busy, m_busy);
      chk("cmp_overflow", overflow, m_ovf);
      chk("cmp_sync_err", sync_err, m_serr);
      chk("cmp_s_tready", s_if.tready, m_tready);
      chk("cmp_m_tvalid", m_if.tvalid, q.size() > 0);
      if (q.size() > 0) begin
        chk("cmp_m_tdata", m_if.tdata, q[0].d);
        chk("cmp_m_tlast", m_if.tlast, q[0].l);
`ifdef SFC_TIMESTAMP_EN
        chk("cmp_m_tuser", m_if.tuser, q[0].u);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit r, input logic [31:0] w0, input logic [31:0] w1);
    s_valid = 1'b1;
    s_user  = r;
    s_data  = {w1, w0};
    tick();
    s_valid = 1'b0;
    s_user  = 1'b0;
  endtask

  task automatic pair(input logic [31:0] l0, input logic [31:0] l1,
                      input logic [31:0] r0, input logic [31:0] r1);
    send(1'b0, l0, l1);
    send(1'b1, r0, r1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 64 && busy; i++) tick();
    chk(name, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_user = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("tready_after_rst", s_if.tready, 1'b1);

    // Basic capture with a free-flowing sink.
    pulse_start();
    chk("basic_busy_set", busy, 1'b1);
    for (int k = 0; k < LEN; k++) begin
      pair(32'h123456AA, 32'h0FEDCB00, 32'h80000111, 32'h7FFFFF22);
      #1;
      chk("basic_tvalid", m_if.tvalid, 1'b1);
      chk("basic_tdata", m_if.tdata, 96'h7FFFFF_0FEDCB_800001_123456);
      chk("basic_tlast", m_if.tlast, k == LEN - 1);
    end
    tick();
    chk("basic_busy_fall", busy, 1'b0);

    // Capture whose first beat is a right beat.
    pulse_start();
    send(1'b1, 32'hDEADBE00, 32'hCAFEBA00);
    chk("rfirst_serr", sync_err, 1'b0);
    pair(32'hAABBCC00, 32'h11223300, 32'h44556600, 32'h778899FF);
    #1;
    chk("rfirst_tdata", m_if.tdata, 96'h778899_112233_445566_AABBCC);
    for (int k = 1; k < LEN; k++) pair(32'(k) << 8, 32'h00000100, 32'h00000200, 32'(k) << 12);
    wait_idle("rfirst_idle");
    chk("rfirst_serr_end", sync_err, 1'b0);

    // Back-pressure: third frame dropped, two drain in order.
    m_ready = 1'b0;
    pulse_start();
    for (int k = 1; k <= 3; k++) pair(32'(k) << 8, 32'h00ABCD00, 32'h00000F00, 32'h00000E00);
    #1;
    chk("bp_overflow", overflow, 1'b1);
    chk("bp_head_tdata", m_if.tdata, 96'h00000E_00ABCD_00000F_000001);
    m_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", m_if.tvalid, 1'b0);
    pair(32'h00000400, 32'h00ABCD00, 32'h00000F00, 32'h00000E00);
    wait_idle("bp_idle");
    chk("bp_overflow_sticky", overflow, 1'b1);

    // New start clears overflow; last frame dropped ends capture without tlast.
    m_ready = 1'b0;
    pulse_start();
    chk("start_clears_ovf", overflow, 1'b0);
    for (int k = 1; k <= LEN; k++) pair(32'(k) << 8, 32'h00555500, 32'h00666600, 32'h00777700);
    #1;
    chk("lastdrop_busy", busy, 1'b0);
    chk("lastdrop_tlast", m_if.tlast, 1'b0);
    m_ready = 1'b1;
    repeat (3) tick();
    chk("lastdrop_drained", m_if.tvalid, 1'b0);

    // Pairing error: L(A), L(B), R(C) gives one frame {B,C}.
    pulse_start();
    send(1'b0, 32'h0A0A0A00, 32'h0B0B0B00);
    send(1'b0, 32'h1C1C1C00, 32'h2D2D2D00);
    send(1'b1, 32'h3E3E3E00, 32'h4F4F4F00);
    #1;
    chk("pair_tdata", m_if.tdata, 96'h4F4F4F_2D2D2D_3E3E3E_1C1C1C);
    chk("pair_serr", sync_err, 1'b1);
    for (int k = 1; k < LEN; k++) pair(32'h01000000, 32'h02000000, 32'h03000000, 32'(k) << 16);
    wait_idle("pair_idle");

    // Stray right beat after a completed frame.
    pulse_start();
    chk("syncl_serr_cleared", sync_err, 1'b0);
    pair(32'h11111100, 32'h22222200, 32'h33333300, 32'h44444400);
    chk("syncl_serr0", sync_err, 1'b0);
    send(1'b1, 32'h99999900, 32'h88888800);
    chk("syncl_serr1", sync_err, 1'b1);
    for (int k = 1; k < LEN; k++) pair(32'h55555500, 32'h66666600, 32'(k) << 8, 32'h77777700);
    wait_idle("syncl_idle");

    // Asynchronous reset in the middle of a capture.
    m_ready = 1'b0;
    pulse_start();
    pair(32'hABCDEF00, 32'h12345600, 32'h65432100, 32'hFEDCBA00);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_m_tvalid", m_if.tvalid, 1'b0);
    chk("arst_m_tdata", m_if.tdata, 96'h0);
    chk("arst_s_tready", s_if.tready, 1'b0);
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("arst_tready_up", s_if.tready, 1'b1);
    chk("arst_busy_idle", busy, 1'b0);

`ifdef SFC_TIMESTAMP_EN
    repeat (5) send(1'b1, 32'h0, 32'h0);
    pulse_start();
    pair(32'h01010100, 32'h02020200, 32'h03030300, 32'h04040400);
    #1;
    chk("ts_first", m_if.tuser, 32'd6);
    pair(32'h01010100, 32'h02020200, 32'h03030300, 32'h04040400);
    #1;
    chk("ts_second", m_if.tuser, 32'd7);
    for (int k = 2; k < LEN; k++) pair(32'h0, 32'h0, 32'h0, 32'h0);
    wait_idle("ts_idle");
    force dut.ts_reg = 32'hFFFFFFFF;
    m_ts = 32'hFFFFFFFF;
    #1;
    release dut.ts_reg;
    pulse_start();
    pair(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("ts_wrap", m_if.tuser, 32'd0);
    for (int k = 1; k < LEN; k++) pair(32'h0, 32'h0, 32'h0, 32'h0);
    wait_idle("ts_wrap_idle");
`endif

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
